hazard_scoreboard: RTL and testbench

- Parametrised successor of the 5-stage pipeline hazard unit.
- Generates forwarding selects and per-stage stall/flush controls from register-operand compares.
- Adds an internal multi-cycle divider occupancy counter in E, which replaces the external divider stall input.
- Adds a HI/LO in-flight writer tracker, so a HI/LO read in D stalls instead of forwarding.
- Operand-use qualifiers suppress false stalls.

---
 rtl/hazard_scoreboard_if.sv | 64 ++++++
 rtl/hazard_scoreboard.sv | 131 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Hazard-unit bundle: pipeline operand/destination info in,
// forwarding selects and stage stall/flush controls out.
interface hazard_scoreboard_if #(
    parameter int AW = 5
);
    logic [AW-1:0] rsD;
    logic [AW-1:0] rtD;
    logic          use_rsD;
    logic          use_rtD;
    logic          branchD;
    logic          hilo_rdD;
    logic [AW-1:0] rsE;
    logic [AW-1:0] rtE;
    logic [AW-1:0] writeregE;
    logic [AW-1:0] writeregM;
    logic [AW-1:0] writeregW;
    logic          regwriteE;
    logic          regwriteM;
    logic          regwriteW;
    logic          memtoregE;
    logic          memtoregM;
    logic          div_startE;
    logic          hilo_wrE;
    logic          flush_except;

    logic [1:0]    forwardaD;
    logic [1:0]    forwardbD;
    logic [1:0]    forwardaE;
    logic [1:0]    forwardbE;
    logic          stallF;
    logic          stallD;
    logic          stallE;
    logic          flushF;
    logic          flushD;
    logic          flushE;
    logic          flushM;
    logic          flushW;
    logic          div_busy;
    logic          hilo_pending;

    modport master (
        output rsD, rtD, use_rsD, use_rtD, branchD, hilo_rdD,
        output rsE, rtE, writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW,
        output memtoregE, memtoregM, div_startE, hilo_wrE,
        output flush_except,
        input  forwardaD, forwardbD, forwardaE, forwardbE,
        input  stallF, stallD, stallE,
        input  flushF, flushD, flushE, flushM, flushW,
        input  div_busy, hilo_pending
    );

    modport slave (
        input  rsD, rtD, use_rsD, use_rtD, branchD, hilo_rdD,
        input  rsE, rtE, writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW,
        input  memtoregE, memtoregM, div_startE, hilo_wrE,
        input  flush_except,
        output forwardaD, forwardbD, forwardaE, forwardbE,
        output stallF, stallD, stallE,
        output flushF, flushD, flushE, flushM, flushW,
        output div_busy, hilo_pending
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// 5-stage hazard unit: forwarding, load/branch/HI-LO stalls,
// and an internal multi-cycle divider occupancy counter in E.
module hazard_scoreboard #(
    parameter int AW      = 5,
    parameter int DIV_LAT = 32
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave hz
);
    localparam int CW = $clog2(DIV_LAT);

    logic [AW-1:0] rs_d, rt_d, rs_e, rt_e;
    logic [AW-1:0] wr_e, wr_m, wr_w;

    assign rs_d = hz.rsD;
    assign rt_d = hz.rtD;
    assign rs_e = hz.rsE;
    assign rt_e = hz.rtE;
    assign wr_e = hz.writeregE;
    assign wr_m = hz.writeregM;
    assign wr_w = hz.writeregW;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    hilo_pipe_q, hilo_pipe_d;

    logic       vm, vw, match_e, match_m;
    logic       lwstall, brstall, histall;
    logic       stall_e, stall_d, hilo_pend;
    logic [1:0] fad, fbd, fae, fbe;

    always_comb begin
        // Writes to r0 never create a dependency.
        vm = hz.regwriteM & (|wr_m);
        vw = hz.regwriteW & (|wr_w);

        fad = 2'b00;
        if (vm && rs_d == wr_m)      fad = 2'b01;
        else if (vw && rs_d == wr_w) fad = 2'b10;

        fbd = 2'b00;
        if (vm && rt_d == wr_m)      fbd = 2'b01;
        else if (vw && rt_d == wr_w) fbd = 2'b10;

        fae = 2'b00;
        if (vm && rs_e == wr_m)      fae = 2'b10;
        else if (vw && rs_e == wr_w) fae = 2'b01;

        fbe = 2'b00;
        if (vm && rt_e == wr_m)      fbe = 2'b10;
        else if (vw && rt_e == wr_w) fbe = 2'b01;

        match_e = (|wr_e) &
                  ((hz.use_rsD & (rs_d == wr_e)) |
                   (hz.use_rtD & (rt_d == wr_e)));
        match_m = (|wr_m) &
                  ((hz.use_rsD & (rs_d == wr_m)) |
                   (hz.use_rtD & (rt_d == wr_m)));

        lwstall = hz.memtoregE & hz.regwriteE & match_e;
        brstall = hz.branchD &
                  ((hz.regwriteE & match_e) |
                   (hz.memtoregM & hz.regwriteM & match_m));

        hilo_pend = hz.hilo_wrE | hilo_pipe_q[0] | hilo_pipe_q[1];
        histall   = hz.hilo_rdD & hilo_pend;

        stall_e = ((div_cnt_q == '0) & hz.div_startE) |
                  (div_cnt_q > CW'(1));
        stall_d = lwstall | brstall | histall | stall_e;
    end

    always_comb begin
        div_cnt_d = '0;
        if (hz.flush_except)
            div_cnt_d = '0;
        else if (div_cnt_q == '0 && hz.div_startE)
            div_cnt_d = CW'(DIV_LAT - 1);
        else if (div_cnt_q > CW'(1))
            div_cnt_d = div_cnt_q - CW'(1);

        // A HI/LO writer held in E by the divider has not left E yet.
        hilo_pipe_d = hz.flush_except ? 2'b00 :
                      {hilo_pipe_q[0], hz.hilo_wrE & ~stall_e};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            hilo_pipe_q <= 2'b00;
        end else begin
            div_cnt_q   <= div_cnt_d;
            hilo_pipe_q <= hilo_pipe_d;
        end
    end

    always_comb begin
        hz.forwardaD    = 2'b00;
        hz.forwardbD    = 2'b00;
        hz.forwardaE    = 2'b00;
        hz.forwardbE    = 2'b00;
        hz.stallF       = 1'b0;
        hz.stallD       = 1'b0;
        hz.stallE       = 1'b0;
        hz.flushF       = 1'b0;
        hz.flushD       = 1'b0;
        hz.flushE       = 1'b0;
        hz.flushM       = 1'b0;
        hz.flushW       = 1'b0;
        hz.div_busy     = 1'b0;
        hz.hilo_pending = 1'b0;
        if (!rst) begin
            hz.forwardaD    = fad;
            hz.forwardbD    = fbd;
            hz.forwardaE    = fae;
            hz.forwardbE    = fbe;
            hz.stallF       = stall_d;
            hz.stallD       = stall_d;
            hz.stallE       = stall_e;
            hz.flushF       = hz.flush_except;
            hz.flushD       = hz.flush_except;
            // No bubble into E while E itself is held.
            hz.flushE       = ((lwstall | brstall | histall) & ~stall_e) |
                              hz.flush_except;
            hz.flushM       = stall_e | hz.flush_except;
            hz.flushW       = hz.flush_except;
            hz.div_busy     = (div_cnt_q != '0);
            hz.hilo_pending = hilo_pend;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (DIV_LAT=4),
// expected output vectors queued per cycle and compared on sampling.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.AW(5)) hz ();

    hazard_scoreboard #(
        .AW      (5),
        .DIV_LAT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct packed {
        logic [1:0] fad, fbd, fae, fbe;
        logic sf, sd, se;
        logic ff, fd, fe, fm, fw;
        logic busy, hp;
    } outs_t;

    typedef struct {
        string tag;
        outs_t exp;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input outs_t got,
                            input outs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    function automatic outs_t sample();
        outs_t s;
        s.fad  = hz.forwardaD;
        s.fbd  = hz.forwardbD;
        s.fae  = hz.forwardaE;
        s.fbe  = hz.forwardbE;
        s.sf   = hz.stallF;
        s.sd   = hz.stallD;
        s.se   = hz.stallE;
        s.ff   = hz.flushF;
        s.fd   = hz.flushD;
        s.fe   = hz.flushE;
        s.fm   = hz.flushM;
        s.fw   = hz.flushW;
        s.busy = hz.div_busy;
        s.hp   = hz.hilo_pending;
        return s;
    endfunction

    // now=1 samples 1 time unit later instead of at the next negedge
    task automatic expect_out(input string tag, input outs_t e,
                              input bit now = 1'b0);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
        if (now) #1;
        else @(negedge clk);
        x = sb.pop_front();
        check_eq(x.tag, sample(), x.exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz.rsD = '0; hz.rtD = '0; hz.use_rsD = 0; hz.use_rtD = 0;
        hz.branchD = 0; hz.hilo_rdD = 0;
        hz.rsE = '0; hz.rtE = '0;
        hz.writeregE = '0; hz.writeregM = '0; hz.writeregW = '0;
        hz.regwriteE = 0; hz.regwriteM = 0; hz.regwriteW = 0;
        hz.memtoregE = 0; hz.memtoregM = 0;
        hz.div_startE = 0; hz.hilo_wrE = 0; hz.flush_except = 0;
    endtask

    function automatic outs_t div_exp(input int k);
        outs_t e;
        e = '0;
        e.busy = (k % 4) != 0;
        if ((k % 4) != 3) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
        end
        return e;
    endfunction

    outs_t e;

    initial begin
        // reset holds every output low despite active inputs
        rst = 1'b1;
        clr();
        hz.rsD = 5; hz.use_rsD = 1; hz.memtoregE = 1;
        hz.regwriteE = 1; hz.writeregE = 5; hz.flush_except = 1;
        hz.div_startE = 1; hz.hilo_wrE = 1;
        hz.writeregM = 5; hz.regwriteM = 1;
        #2;
        expect_out("rst_now", '0, 1'b1);
        expect_out("rst_edge", '0);
        cyc();
        clr();
        rst = 1'b0;
        expect_out("idle", '0);

        // load-use stall
        cyc(); clr();
        hz.memtoregE = 1; hz.regwriteE = 1; hz.writeregE = 5;
        hz.rsD = 5; hz.use_rsD = 1;
        e = '0; e.sf = 1; e.sd = 1; e.fe = 1;
        expect_out("lw_rs", e);
        cyc();
        hz.use_rsD = 0; hz.rtD = 5;
        expect_out("lw_nouse", '0);
        cyc();
        hz.use_rtD = 1;
        expect_out("lw_rt", e);

        // forwarding priority
        cyc(); clr();
        hz.writeregM = 7; hz.writeregW = 7;
        hz.regwriteM = 1; hz.regwriteW = 1;
        hz.rsE = 7; hz.rtD = 7;
        e = '0; e.fae = 2'b10; e.fbd = 2'b01;
        expect_out("fwd_m", e);
        cyc();
        hz.regwriteM = 0; hz.rtE = 7;
        e = '0; e.fae = 2'b01; e.fbe = 2'b01; e.fbd = 2'b10;
        expect_out("fwd_w", e);
        cyc(); clr();
        hz.regwriteE = 1; hz.regwriteM = 1; hz.regwriteW = 1;
        hz.memtoregE = 1; hz.branchD = 1;
        hz.use_rsD = 1; hz.use_rtD = 1;
        expect_out("r0", '0);

        // branch stalls
        cyc(); clr();
        hz.branchD = 1; hz.regwriteE = 1; hz.writeregE = 3;
        hz.rsD = 3; hz.use_rsD = 1;
        e = '0; e.sf = 1; e.sd = 1; e.fe = 1;
        expect_out("br_e", e);
        cyc(); clr();
        hz.branchD = 1; hz.memtoregM = 1; hz.regwriteM = 1;
        hz.writeregM = 4; hz.rtD = 4; hz.use_rtD = 1;
        e = '0; e.sf = 1; e.sd = 1; e.fe = 1; e.fbd = 2'b01;
        expect_out("br_m", e);
        cyc();
        hz.branchD = 0;
        e = '0; e.fbd = 2'b01;
        expect_out("nobr_m", e);

        // two back-to-back divides, load-use overlapping the first
        cyc(); clr();
        hz.div_startE = 1;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) begin
                hz.memtoregE = 1; hz.regwriteE = 1; hz.writeregE = 5;
                hz.rsD = 5; hz.use_rsD = 1;
            end
            if (k == 2) begin
                hz.memtoregE = 0; hz.regwriteE = 0; hz.writeregE = 0;
                hz.rsD = 0; hz.use_rsD = 0;
            end
            expect_out($sformatf("div%0d", k), div_exp(k));
            cyc();
        end
        hz.div_startE = 0;
        expect_out("div_done", '0);

        // HI/LO in-flight writer
        cyc(); clr();
        hz.hilo_wrE = 1;
        e = '0; e.hp = 1;
        expect_out("hilo_wr", e);
        cyc();
        hz.hilo_wrE = 0; hz.hilo_rdD = 1;
        e = '0; e.hp = 1; e.sf = 1; e.sd = 1; e.fe = 1;
        expect_out("hilo_rd1", e);
        cyc();
        expect_out("hilo_rd2", e);
        cyc();
        expect_out("hilo_rd3", '0);

        // exception flush clears HI/LO tracker
        cyc(); clr();
        hz.hilo_wrE = 1;
        e = '0; e.hp = 1;
        expect_out("hw2", e);
        cyc();
        hz.hilo_wrE = 0; hz.flush_except = 1;
        e = '0; e.hp = 1;
        e.ff = 1; e.fd = 1; e.fe = 1; e.fm = 1; e.fw = 1;
        expect_out("hflush", e);
        cyc();
        hz.flush_except = 0;
        expect_out("hflush_after", '0);

        // exception flush mid-divide (counter at 2)
        cyc(); clr();
        hz.div_startE = 1;
        expect_out("dfl0", div_exp(0));
        cyc();
        expect_out("dfl1", div_exp(1));
        cyc();
        hz.flush_except = 1;
        e = '0; e.sf = 1; e.sd = 1; e.se = 1; e.busy = 1;
        e.ff = 1; e.fd = 1; e.fe = 1; e.fm = 1; e.fw = 1;
        expect_out("dflush", e);
        cyc(); clr();
        expect_out("dflush_after", '0);

        // asynchronous reset between edges mid-divide
        cyc(); clr();
        hz.div_startE = 1;
        expect_out("ar0", div_exp(0));
        cyc();
        expect_out("ar1", div_exp(1));
        #1;
        rst = 1'b1;
        hz.div_startE = 0;
        expect_out("arst", '0, 1'b1);
        rst = 1'b0;
        expect_out("arst_rel", '0, 1'b1);
        cyc();
        expect_out("arst_next", '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
